// File: rtl/nbody_readback.sv
// nbody_readback: Avalon-MM master that drains finished nbody frames.
// Each frame it polls DONE, reads every body's x/y double, converts both
// to clamped screen coordinates and streams one pixel record per body.
// Afterwards it runs the READ/DONE handshake so nbody can start the next frame.
module nbody_readback #(
    parameter int BODIES      = 512,
    parameter int IDX_W       = $clog2(BODIES),
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 64,
    parameter int SCR_W       = 640,
    parameter int SCR_H       = 480,
    parameter int PIX_W       = 10,
    parameter int SCALE_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [IDX_W-1:0]      num_bodies,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_read,
    output logic                  m_write,
    output logic                  m_chipselect,
    output logic [DATA_WIDTH-1:0] m_writedata,
    input  logic [DATA_WIDTH-1:0] m_readdata,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [PIX_W-1:0]      pix_x,
    output logic [PIX_W-1:0]      pix_y,
    output logic [IDX_W-1:0]      pix_idx,
    output logic                  pix_last,
    output logic                  frame_done,
    output logic                  busy
);

    // Sum width leaves room for origin +/- an (PIX_W+1)-bit magnitude.
    localparam int S_W = PIX_W + 3;
    localparam int M_W = PIX_W + 1;

    // Upper address bits selecting nbody registers / memories.
    localparam logic [6:0] PG_DONE = 7'b1000000;
    localparam logic [6:0] PG_X    = 7'b1000001;
    localparam logic [6:0] PG_Y    = 7'b1000010;
    localparam logic [6:0] PG_FLAG = 7'b0000001;

    localparam logic [S_W-1:0]   ORG_X = S_W'(SCR_W / 2);
    localparam logic [S_W-1:0]   ORG_Y = S_W'(SCR_H / 2);
    localparam logic [PIX_W-1:0] MAX_X = PIX_W'(SCR_W - 1);
    localparam logic [PIX_W-1:0] MAX_Y = PIX_W'(SCR_H - 1);

    typedef enum logic [3:0] {
        IDLE, POLL_DONE, RD_X, RD_Y, CONV, EMIT, ACK, WAIT_CLR, RELEASE, FDONE
    } state_t;

    state_t state_r, state_s;
    logic   phase_r, phase_s;           // 0 = first, 1 = second cycle of a read
    logic [IDX_W-1:0] idx_r, idx_s;
    logic [IDX_W-1:0] nb_r;
    logic [63:0]      xr_r, yr_r;

    logic                  m_read_s, m_write_s, wbit_s;
    logic [ADDR_WIDTH-1:0] m_addr_s;

    // Convert a double to a screen coordinate around origin, clamped to 0..lim.
    function automatic logic [PIX_W-1:0] to_coord(input logic [63:0] v,
                                                  input logic [S_W-1:0] origin,
                                                  input logic [PIX_W-1:0] lim);
        logic [10:0]           exp_f;
        int                    e_i;
        logic [5:0]            sh;
        logic [M_W-1:0]        mag;
        logic                  sat;
        logic signed [S_W-1:0] s;
        logic [PIX_W-1:0]      res;
        exp_f = v[62:52];
        e_i   = int'(exp_f) - 32'sd1023 - SCALE_SHIFT;
        sh    = 6'd0;
        mag   = '0;
        sat   = 1'b0;
        s     = '0;
        res   = '0;
        if (exp_f == 11'd0 || e_i < 32'sd0) begin
            mag = '0;
        end else if (exp_f == 11'h7FF || e_i >= PIX_W + 1) begin
            sat = 1'b1;
        end else begin
            sh  = 6'(32'sd52 - e_i);
            mag = M_W'({1'b1, v[51:0]} >> sh);
        end
        if (sat) begin
            res = v[63] ? '0 : lim;
        end else begin
            if (v[63]) begin
                s = $signed(origin) - $signed({{(S_W-M_W){1'b0}}, mag});
            end else begin
                s = $signed(origin) + $signed({{(S_W-M_W){1'b0}}, mag});
            end
            if (s[S_W-1]) begin
                res = '0;
            end else if (s > $signed({{(S_W-PIX_W){1'b0}}, lim})) begin
                res = lim;
            end else begin
                res = s[PIX_W-1:0];
            end
        end
        return res;
    endfunction

    // State and read-phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            phase_r <= 1'b0;
        end else begin
            state_r <= state_s;
            phase_r <= phase_s;
        end
    end

    // Next-state logic; reads finish when phase_r is 1 (data sampled then).
    always_comb begin
        state_s = state_r;
        phase_s = 1'b0;
        idx_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (enable) begin
                    state_s = POLL_DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            POLL_DONE: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else if (m_readdata[0]) begin
                    idx_s   = '0;
                    state_s = (nb_r == '0) ? ACK : RD_X;
                end else begin
                    state_s = POLL_DONE;
                end
            end
            RD_X: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else begin
                    state_s = RD_Y;
                end
            end
            RD_Y: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else begin
                    state_s = CONV;
                end
            end
            CONV: state_s = EMIT;
            EMIT: begin
                if (pix_ready) begin
                    if (pix_last) begin
                        state_s = ACK;
                    end else begin
                        state_s = RD_X;
                        idx_s   = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = EMIT;
                end
            end
            ACK: state_s = WAIT_CLR;
            WAIT_CLR: begin
                if (!phase_r) begin
                    phase_s = 1'b1;
                end else if (!m_readdata[0]) begin
                    state_s = RELEASE;
                end else begin
                    state_s = WAIT_CLR;
                end
            end
            RELEASE: state_s = FDONE;
            FDONE:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Bus command for the upcoming state, registered below so strobes are glitch-free.
    always_comb begin
        m_read_s  = 1'b0;
        m_write_s = 1'b0;
        wbit_s    = 1'b0;
        m_addr_s  = '0;
        case (state_s)
            POLL_DONE, WAIT_CLR: begin
                m_read_s = 1'b1;
                m_addr_s = ADDR_WIDTH'({PG_DONE, {IDX_W{1'b0}}});
            end
            RD_X: begin
                m_read_s = 1'b1;
                m_addr_s = ADDR_WIDTH'({PG_X, idx_s});
            end
            RD_Y: begin
                m_read_s = 1'b1;
                m_addr_s = ADDR_WIDTH'({PG_Y, idx_s});
            end
            ACK: begin
                m_write_s = 1'b1;
                wbit_s    = 1'b1;
                m_addr_s  = ADDR_WIDTH'({PG_FLAG, {IDX_W{1'b0}}});
            end
            RELEASE: begin
                m_write_s = 1'b1;
                m_addr_s  = ADDR_WIDTH'({PG_FLAG, {IDX_W{1'b0}}});
            end
            default: begin
                m_read_s = 1'b0;
            end
        endcase
    end

    // Registered bus and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_addr       <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_chipselect <= 1'b0;
            m_writedata  <= '0;
            pix_valid    <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            m_addr       <= m_addr_s;
            m_read       <= m_read_s;
            m_write      <= m_write_s;
            m_chipselect <= m_read_s | m_write_s;
            m_writedata  <= {{(DATA_WIDTH-1){1'b0}}, wbit_s};
            pix_valid    <= (state_s == EMIT);
            frame_done   <= (state_s == FDONE);
            busy         <= (state_s != IDLE);
        end
    end

    // Frame datapath: body index, captured positions and the pixel record.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r    <= '0;
            nb_r     <= '0;
            xr_r     <= '0;
            yr_r     <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
            pix_idx  <= '0;
            pix_last <= 1'b0;
        end else begin
            idx_r <= idx_s;
            if (state_r == IDLE && enable) begin
                nb_r <= num_bodies;
            end else begin
                nb_r <= nb_r;
            end
            if (state_r == RD_X && phase_r) begin
                xr_r <= m_readdata[63:0];
            end else begin
                xr_r <= xr_r;
            end
            if (state_r == RD_Y && phase_r) begin
                yr_r <= m_readdata[63:0];
            end else begin
                yr_r <= yr_r;
            end
            if (state_r == CONV) begin
                pix_x    <= to_coord(xr_r, ORG_X, MAX_X);
                pix_y    <= to_coord(yr_r, ORG_Y, MAX_Y);
                pix_idx  <= idx_r;
                pix_last <= (idx_r == nb_r - IDX_W'(1));
            end else begin
                pix_x    <= pix_x;
                pix_y    <= pix_y;
                pix_idx  <= pix_idx;
                pix_last <= pix_last;
            end
        end
    end

endmodule

// File: tb/tb_nbody_readback.sv
// Testbench for nbody_readback: nbody slave model, scoreboard and monitor.
module tb_nbody_readback;
    localparam int BODIES = 512, IDX_W = 9, AW = 16, DW = 64;
    localparam int SCR_W = 640, SCR_H = 480, PIX_W = 10, SCALE_SHIFT = 0;

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, pix_ready = 1'b1;
    logic [IDX_W-1:0] num_bodies = '0;
    logic [DW-1:0] m_readdata = '0;
    logic [AW-1:0] m_addr;
    logic m_read, m_write, m_chipselect, pix_valid, pix_last, frame_done, busy;
    logic [DW-1:0] m_writedata;
    logic [PIX_W-1:0] pix_x, pix_y;
    logic [IDX_W-1:0] pix_idx;

    nbody_readback #(.BODIES(BODIES), .IDX_W(IDX_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                     .SCR_W(SCR_W), .SCR_H(SCR_H), .PIX_W(PIX_W), .SCALE_SHIFT(SCALE_SHIFT))
    dut (.clk(clk), .rst(rst), .enable(enable), .num_bodies(num_bodies),
         .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_chipselect(m_chipselect),
         .m_writedata(m_writedata), .m_readdata(m_readdata), .pix_valid(pix_valid),
         .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_idx(pix_idx),
         .pix_last(pix_last), .frame_done(frame_done), .busy(busy));

    always #5 clk = ~clk;

    typedef struct { int x; int y; int idx; bit last; } rec_t;
    typedef struct { int addr; longint data; } wr_t;
    rec_t pix_q[$];
    wr_t  wr_q[$];
    int checks = 0, failures = 0;
    bit [63:0] xs [BODIES];
    bit [63:0] ys [BODIES];
    int pub_gen = 0, acked_gen = 0;
    int ready_mode = 0, stall_seen = 0, fd_count = 0, exp_frames = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference conversion: truncate |v|/2^SCALE_SHIFT, offset from origin, clamp.
    function automatic int ref_coord(input bit [63:0] v, input int o, input int mx);
        real a;
        int  m, s;
        bit [10:0] ex;
        ex = v[62:52];
        if (ex == 11'h7FF) return v[63] ? 0 : mx;
        if (ex == 11'd0) return o;
        a = $bitstoreal(v);
        if (a < 0.0) a = -a;
        for (int k = 0; k < SCALE_SHIFT; k++) a = a / 2.0;
        if (a >= 2048.0) return v[63] ? 0 : mx;
        m = $rtoi(a);
        s = v[63] ? o - m : o + m;
        if (s < 0) return 0;
        if (s > mx) return mx;
        return s;
    endfunction

    function automatic bit [63:0] rand_pos();
        bit [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: r[62:0] = 63'd0;
            1: r[62:0] = {11'h7FF, 52'd0};
            2: r[62:52] = 11'h7FF;
            3: r[62:52] = 11'd0;
            4: r[62:52] = 11'd1100;
            default: r[62:52] = 11'(1013 + $urandom_range(0, 22));
        endcase
        return r;
    endfunction

    function automatic bit [63:0] slave_read(input logic [AW-1:0] a);
        case (a[15:9])
            7'b1000000: return {63'd0, pub_gen != acked_gen};
            7'b1000001: return xs[a[8:0]];
            7'b1000010: return ys[a[8:0]];
            default:    return 64'd0;
        endcase
    endfunction

    // nbody slave: data valid only in the second cycle of a held read; ACK clears DONE later.
    logic [AW-1:0] prev_addr = '0;
    bit prev_rd = 1'b0, ack_pend = 1'b0;
    int ack_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (m_read && prev_rd && m_addr == prev_addr) m_readdata = slave_read(m_addr);
        else m_readdata = {$urandom, $urandom};
        prev_rd = m_read;
        prev_addr = m_addr;
        if (ack_pend) begin
            if (ack_cnt == 0) begin acked_gen = pub_gen; ack_pend = 1'b0; end
            else ack_cnt--;
        end
        if (m_write && m_addr == 16'h0200 && m_writedata[0]) begin
            ack_pend = 1'b1;
            ack_cnt = $urandom_range(0, 4);
        end
    end

    // Downstream ready: always, random, or a 5-cycle stall on record 1.
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: pix_ready = ($urandom_range(0, 9) < 6);
            2: begin
                if (pix_valid && pix_idx == 0) stall_cnt = 0;
                if (pix_valid && pix_idx == 1 && stall_cnt < 5) begin
                    pix_ready = 1'b0;
                    stall_cnt++;
                end else pix_ready = 1'b1;
            end
            default: pix_ready = 1'b1;
        endcase
    end

    // Monitor: protocol checks and scoreboard pops on every accepted record / write.
    bit prev_valid = 0, prev_acc = 0, prev_fd = 0;
    logic [PIX_W-1:0] px_p, py_p;
    logic [IDX_W-1:0] pi_p;
    logic pl_p;
    logic [AW-1:0] run_addr;
    int run_len = 0;
    always @(negedge clk) begin
        rec_t r;
        wr_t w;
        if (rst) begin
            chk({busy, pix_valid, m_read, m_write, frame_done, m_chipselect} === 6'd0,
                "reset_ctrl", {busy, pix_valid, m_read, m_write, frame_done, m_chipselect}, 0);
            chk(m_addr === '0 && m_writedata === '0, "reset_bus", m_addr, 0);
            chk(pix_x === '0 && pix_y === '0 && pix_idx === '0 && pix_last === 1'b0,
                "reset_pix", {pix_x, pix_y}, 0);
            run_len = 0; prev_valid = 0; prev_fd = 0;
        end else begin
            chk(m_chipselect === (m_read | m_write), "chipselect", m_chipselect, m_read | m_write);
            if (pix_valid) chk(!m_read, "read_while_valid", m_read, 0);
            if (prev_valid && !prev_acc)
                chk(pix_valid && pix_x == px_p && pix_y == py_p && pix_idx == pi_p && pix_last == pl_p,
                    "pix_hold", {pix_valid, pix_x, pix_y, pix_idx, pix_last},
                    {1'b1, px_p, py_p, pi_p, pl_p});
            if (pix_valid && !pix_ready && pix_idx == 1 && ready_mode == 2) stall_seen++;
            if (pix_valid && pix_ready) begin
                if (pix_q.size() == 0) chk(1'b0, "unexpected_pix", pix_idx, -1);
                else begin
                    r = pix_q.pop_front();
                    chk(pix_x == r.x, "pix_x", pix_x, r.x);
                    chk(pix_y == r.y, "pix_y", pix_y, r.y);
                    chk(pix_idx == r.idx, "pix_idx", pix_idx, r.idx);
                    chk(pix_last == r.last, "pix_last", pix_last, r.last);
                end
            end
            prev_valid = pix_valid; prev_acc = pix_valid && pix_ready;
            px_p = pix_x; py_p = pix_y; pi_p = pix_idx; pl_p = pix_last;
            if (m_write) begin
                if (wr_q.size() == 0) chk(1'b0, "unexpected_write", m_addr, -1);
                else begin
                    w = wr_q.pop_front();
                    chk(m_addr == w.addr, "wr_addr", m_addr, w.addr);
                    chk(m_writedata == w.data, "wr_data", m_writedata, w.data);
                end
            end
            if (m_read && run_len > 0 && m_addr == run_addr) run_len++;
            else begin
                if (run_len > 0) chk(run_len % 2 == 0, "read_len", run_len, 2);
                run_len = m_read ? 1 : 0;
                run_addr = m_addr;
            end
            if (frame_done) begin
                fd_count++;
                chk(!prev_fd, "fd_pulse", 2, 1);
            end
            prev_fd = frame_done;
        end
    end

    task automatic push_rec(input int x, input int y, input int idx, input bit last);
        pix_q.push_back('{x, y, idx, last});
    endtask

    task automatic push_model(input int nb);
        for (int i = 0; i < nb; i++)
            push_rec(ref_coord(xs[i], SCR_W / 2, SCR_W - 1), ref_coord(ys[i], SCR_H / 2, SCR_H - 1),
                     i, i == nb - 1);
    endtask

    task automatic push_tail();
        wr_q.push_back('{16'h0200, 64'd1});
        wr_q.push_back('{16'h0200, 64'd0});
        exp_frames++;
    endtask

    task automatic randomize_bodies(input int nb);
        for (int i = 0; i < nb; i++) begin xs[i] = rand_pos(); ys[i] = rand_pos(); end
    endtask

    task automatic start_frame(input int nb);
        num_bodies = IDX_W'(nb);
        enable = 1'b1;
        pub_gen++;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!frame_done && n < 4000);
        chk(frame_done, name, n, 4000);
        #1 enable = 1'b0;
        repeat (4) @(negedge clk);
        chk(pix_q.size() == 0, "pix_leftover", pix_q.size(), 0);
        chk(wr_q.size() == 0, "wr_leftover", wr_q.size(), 0);
        #1;
    endtask

    initial begin
        int s0, n;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;

        xs[0] = $realtobits(0.0); ys[0] = $realtobits(0.0);
        push_rec(320, 240, 0, 1); push_tail(); start_frame(1); wait_frame("frame_zero");

        xs[0] = 64'h4059200000000000; ys[0] = $realtobits(-50.9);
        xs[1] = $realtobits(-1000.0); ys[1] = $realtobits(1.0e6);
        push_rec(420, 190, 0, 0); push_rec(0, 479, 1, 1); push_tail();
        start_frame(2); wait_frame("frame_basic");

        xs[0] = 64'h7FF0000000000000; ys[0] = 64'h0000000000000001;
        xs[1] = 64'h0000000000000001; ys[1] = 64'hFFF0000000000000;
        push_rec(639, 240, 0, 0); push_rec(320, 0, 1, 1); push_tail();
        start_frame(2); wait_frame("frame_special");

        ready_mode = 2; s0 = stall_seen;
        randomize_bodies(3); push_model(3); push_tail();
        start_frame(3); wait_frame("frame_stall");
        chk(stall_seen - s0 == 5, "stall_cycles", stall_seen - s0, 5);
        ready_mode = 0;

        num_bodies = IDX_W'(2); enable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk(!pix_valid, "poll_no_pix", pix_valid, 0);
            if (m_read) chk(m_addr == 16'h8000, "poll_addr", m_addr, 16'h8000);
        end
        #1 randomize_bodies(2); push_model(2); push_tail(); pub_gen++;
        wait_frame("frame_late_done");

        randomize_bodies(4); push_model(4); push_tail(); start_frame(4);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(m_read && m_addr == 16'h8402) && n < 2000);
        chk(n < 2000, "rd_y_seen", n, 2000);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 pix_q.delete(); wr_q.delete(); exp_frames--; rst = 1'b0;
        push_model(4); push_tail();
        wait_frame("frame_after_reset");

        push_tail(); start_frame(0); wait_frame("frame_empty");

        ready_mode = 1;
        repeat (6) begin
            n = $urandom_range(1, 6);
            randomize_bodies(n); push_model(n); push_tail(); start_frame(n);
            wait_frame("frame_random");
        end
        ready_mode = 0;

        repeat (5) @(negedge clk);
        chk(fd_count == exp_frames, "frame_count", fd_count, exp_frames);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end
endmodule

// File: doc/nbody_readback.md
Name: nbody_readback

Overview:
- Downstream consumer of the nbody accelerator. It is an Avalon-MM master wired directly to the nbody slave port.
- On each finished frame it fetches every body's x/y position (64-bit IEEE-754 double) and converts each to clamped integer screen coordinates.
- It streams one pixel record per body to the display/sprite stage.
- It runs the nbody DONE/READ handshake in place of software, so the simulation free-runs while the readout is shown.

Parameters:
- BODIES, 512, max body count; IDX_W = $clog2(BODIES).
- ADDR_WIDTH, 16, nbody slave address width.
- DATA_WIDTH, 64, nbody slave data width.
- SCR_W, 640, screen width in pixels; x output range 0..SCR_W-1.
- SCR_H, 480, screen height in pixels; y output range 0..SCR_H-1.
- PIX_W, 10, pixel coordinate width.
- SCALE_SHIFT, 0, positions are multiplied by 2^-SCALE_SHIFT before truncation.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  allow frame readout; sampled in IDLE only.
- num_bodies  in  IDX_W  bodies per frame; same value software gave nbody.
- m_addr  out  ADDR_WIDTH  address to nbody.
- m_read  out  1  read strobe.
- m_write  out  1  write strobe.
- m_chipselect  out  1  m_read | m_write.
- m_writedata  out  DATA_WIDTH  write data.
- m_readdata  in  DATA_WIDTH  nbody readdata.
- pix_valid  out  1  pixel record valid.
- pix_ready  in  1  downstream accepts the record.
- pix_x  out  PIX_W  screen x.
- pix_y  out  PIX_W  screen y.
- pix_idx  out  IDX_W  body index.
- pix_last  out  1  record is the last of the frame.
- frame_done  out  1  one-cycle pulse after the handshake is released.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: state=IDLE. All outputs 0: m_addr, strobes, writedata, pix_*, frame_done, busy. Index counter and captured x/y registers cleared.
- Address map, upper 7 bits {body index in low IDX_W bits}:
  - DONE = 1000000.
  - READ_X = 1000001.
  - READ_Y = 1000010.
  - READ flag write = 0000001.
- Every bus read is 2 cycles. m_read and m_addr are held for both cycles; m_readdata is sampled at the end of cycle 2 (covers nbody's 1-cycle RAM read latency).
- Writes are 1 cycle: m_write=1, m_writedata={63'b0,bit}.
- FSM:
  - IDLE -> POLL_DONE when enable=1.
  - POLL_DONE: 2-cycle read of DONE. Sampled bit 1 -> RD_X with idx=0 (or ACK if num_bodies=0). Sampled bit 0 -> repeat POLL_DONE.
  - RD_X: 2-cycle read at READ_X|idx, capture xr -> RD_Y.
  - RD_Y: 2-cycle read at READ_Y|idx, capture yr -> CONV.
  - CONV: 1 cycle; register pix_x/pix_y/pix_idx, set pix_last=(idx==num_bodies-1), pix_valid=1 -> EMIT.
  - EMIT: hold all pix_* stable until pix_valid&pix_ready. On that cycle drop pix_valid; go to RD_X with idx+1 if not last, else ACK.
  - ACK: write READ=1 -> WAIT_CLR.
  - WAIT_CLR: poll DONE (2-cycle reads) until it reads 0 -> RELEASE.
  - RELEASE: write READ=0 -> FDONE.
  - FDONE: frame_done=1 for one cycle -> IDLE.
- Conversion of a double v to a coordinate, with origin O = SCR_W/2 for x and SCR_H/2 for y:
  - e = exp - 1023 - SCALE_SHIFT.
  - exp field 0, or e<0 -> magnitude 0.
  - exp field 2047, or e>=PIX_W+1 -> saturate: result 0 if sign=1, else max.
  - Otherwise mag = {1,mant} >> (52-e), i.e. truncation toward zero.
  - Signed sum s = O ± mag, computed at ≥ PIX_W+2 bits.
  - Clamp: s<0 -> 0; s>max -> max, where max is SCR_W-1 or SCR_H-1.
- Simultaneous events: enable deasserting mid-frame has no effect; the frame completes through FDONE. pix_ready is ignored outside EMIT.
- Bus reads are not issued while pix_valid=1.
- Reset mid-frame returns the block to IDLE immediately. nbody's READ flag may be left at 1; software must clear it.
- num_bodies is sampled on IDLE->POLL_DONE and held for the whole frame.

Test Plan:
- Body 0 x=0.0, y=0.0, num_bodies=1, DONE=1 -> one record pix_x=320, pix_y=240, pix_idx=0, pix_last=1. Then READ=1 written, DONE polled to 0, READ=0 written, frame_done pulses.
- x=100.5 (0x4059200000000000), y=-50.9 -> pix_x=420, pix_y=190.
- x=-1000.0 -> pix_x=0. y=1.0e6 -> pix_y=479. x=+inf -> 639. x=subnormal 0x0000000000000001 -> 320.
- num_bodies=3, pix_ready low for 5 cycles on record 1 -> record 1 held stable for all 5 cycles and no bus read issued meanwhile. Records arrive with pix_idx 0,1,2 and pix_last only on idx 2.
- DONE held 0 for 20 cycles -> only DONE polls appear, each 2 cycles at address 0x8000; no pixel output.
- rst asserted during RD_Y -> next cycle busy=0, pix_valid=0, m_read=0. With enable=1, the next frame restarts at idx 0.
- num_bodies=0 with DONE=1 -> no pix_valid. ACK / WAIT_CLR / RELEASE sequence runs, then frame_done pulses.
